// File: rtl/ioconfig_loader.sv
// rtl/ioconfig_loader.sv - serial IOB configuration frame loader
//
// Hunts the serial stream for SYNC_WORD, shifts in one frame of 3 bits per
// IOB (TSMUX[1], TSMUX[0], DORREG for IOB 0 first), checks a trailing even
// parity bit, and applies the whole frame to the IOB configuration outputs
// in one edge only when parity passes.
//
// Ports:
//   IOCLK       clock, all state updates on the rising edge
//   RST         asynchronous active-high reset
//   CFG_DIN     serial configuration bit
//   CFG_VALID   CFG_DIN is sampled only when high
//   TSMUX_ALL   IOB i tristate select at [2i+1:2i]
//   DORREG_ALL  IOB i input select at [i] (0 direct, 1 registered)
//   CFG_DONE    sticky, set once any frame has been applied
//   CFG_ERR     one-cycle pulse on parity failure
//   BUSY        frame body or parity bit being received

module ioconfig_loader #(
    parameter int         NUM_IOB   = 8,
    parameter logic [7:0] SYNC_WORD = 8'hA5
) (
    input  logic                   IOCLK,
    input  logic                   RST,
    input  logic                   CFG_DIN,
    input  logic                   CFG_VALID,
    output logic [2*NUM_IOB-1:0]   TSMUX_ALL,
    output logic [NUM_IOB-1:0]     DORREG_ALL,
    output logic                   CFG_DONE,
    output logic                   CFG_ERR,
    output logic                   BUSY
);

    localparam int            BODY_BITS = 3 * NUM_IOB;
    localparam int            CW        = $clog2(BODY_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(BODY_BITS - 1);

    localparam logic [1:0] S_HUNT   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    logic [1:0]           state;
    logic [7:0]           sync_sr;
    logic [7:0]           sync_next;
    logic [CW-1:0]        bit_cnt;
    logic [BODY_BITS-1:0] staging;
    logic                 body_par;
    logic [2*NUM_IOB-1:0] ts_stage;
    logic [NUM_IOB-1:0]   dor_stage;

    assign sync_next = {sync_sr[6:0], CFG_DIN};
    assign BUSY      = (state == S_LOAD) || (state == S_PARITY);

    // The first body bit shifts all the way to the MSB, so IOB i's triplet
    // sits at the top of the staging register counting down from MSB.
    always_comb begin
        ts_stage  = '0;
        dor_stage = '0;
        for (int i = 0; i < NUM_IOB; i++) begin
            ts_stage[2*i+1] = staging[BODY_BITS-1-3*i];
            ts_stage[2*i]   = staging[BODY_BITS-2-3*i];
            dor_stage[i]    = staging[BODY_BITS-3-3*i];
        end
    end

    always_ff @(posedge IOCLK or posedge RST) begin
        if (RST) begin
            state      <= S_HUNT;
            sync_sr    <= '0;
            bit_cnt    <= '0;
            staging    <= '0;
            body_par   <= 1'b0;
            TSMUX_ALL  <= '0;
            DORREG_ALL <= '0;
            CFG_DONE   <= 1'b0;
            CFG_ERR    <= 1'b0;
        end else begin
            CFG_ERR <= 1'b0;
            if (CFG_VALID) begin
                case (state)
                    S_HUNT: begin
                        sync_sr <= sync_next;
                        if (sync_next == SYNC_WORD) begin
                            bit_cnt  <= '0;
                            staging  <= '0;
                            body_par <= 1'b0;
                            state    <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        // Sync patterns in the body are plain data: no hunting here.
                        staging  <= {staging[BODY_BITS-2:0], CFG_DIN};
                        body_par <= body_par ^ CFG_DIN;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        if ((body_par ^ CFG_DIN) == 1'b0) begin
                            TSMUX_ALL  <= ts_stage;
                            DORREG_ALL <= dor_stage;
                            CFG_DONE   <= 1'b1;
                        end else begin
                            CFG_ERR <= 1'b1;
                        end
                        // Cleared so the next frame needs all 8 sync bits again.
                        sync_sr <= '0;
                        state   <= S_HUNT;
                    end
                    default: begin
                        state <= S_HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ioconfig_loader.sv
// tb/tb_ioconfig_loader.sv - scoreboard bench for ioconfig_loader

module tb_ioconfig_loader;

    logic       IOCLK = 1'b0;
    logic       RST;
    logic       CFG_DIN;
    logic       CFG_VALID;
    logic [3:0] TSMUX_ALL;
    logic [1:0] DORREG_ALL;
    logic       CFG_DONE;
    logic       CFG_ERR;
    logic       BUSY;

    ioconfig_loader #(.NUM_IOB(2), .SYNC_WORD(8'hA5)) dut (
        .IOCLK      (IOCLK),
        .RST        (RST),
        .CFG_DIN    (CFG_DIN),
        .CFG_VALID  (CFG_VALID),
        .TSMUX_ALL  (TSMUX_ALL),
        .DORREG_ALL (DORREG_ALL),
        .CFG_DONE   (CFG_DONE),
        .CFG_ERR    (CFG_ERR),
        .BUSY       (BUSY)
    );

    always #5 IOCLK = ~IOCLK;

    typedef struct {
        logic [3:0] ts;
        logic [1:0] dor;
        logic       done;
        logic       err;
        int         stamp;
    } ev_t;

    ev_t exp_q[$];
    int  busy_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;

    always @(posedge IOCLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: any output change or error pulse is an event to score.
    logic [3:0] prev_ts   = '0;
    logic [1:0] prev_dor  = '0;
    logic       prev_done = 1'b0;
    int         busy_run  = 0;
    ev_t        mon_e;
    int         exp_busy;

    always @(negedge IOCLK) begin
        if (TSMUX_ALL !== prev_ts || DORREG_ALL !== prev_dor ||
            CFG_DONE !== prev_done || CFG_ERR !== 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: ts=%b dor=%b done=%b err=%b expected no event",
                         TSMUX_ALL, DORREG_ALL, CFG_DONE, CFG_ERR);
            end else begin
                mon_e = exp_q.pop_front();
                check("tsmux", 32'(TSMUX_ALL), 32'(mon_e.ts));
                check("dorreg", 32'(DORREG_ALL), 32'(mon_e.dor));
                check("cfg_done", 32'(CFG_DONE), 32'(mon_e.done));
                check("cfg_err", 32'(CFG_ERR), 32'(mon_e.err));
                if (mon_e.stamp >= 0) check("apply_cycle", 32'(cyc), 32'(mon_e.stamp));
            end
        end
        prev_ts   = TSMUX_ALL;
        prev_dor  = DORREG_ALL;
        prev_done = CFG_DONE;

        if (BUSY === 1'b1) begin
            busy_run++;
        end else if (busy_run > 0) begin
            if (busy_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_busy: got %0d cycles expected none", busy_run);
            end else begin
                exp_busy = busy_q.pop_front();
                check("busy_cycles", 32'(busy_run), 32'(exp_busy));
            end
            busy_run = 0;
        end
    end

    task automatic send(input logic b, input logic v);
        @(negedge IOCLK);
        CFG_DIN   = b;
        CFG_VALID = v;
    endtask

    task automatic send_v(input logic b, input bit gaps);
        send(b, 1'b1);
        if (gaps) send(~b, 1'b0);
    endtask

    task automatic send_sync(input bit gaps);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 7; i >= 0; i--) send_v(s[i], gaps);
    endtask

    task automatic frame(input logic [5:0] body, input logic par, input bit gaps,
                         input logic [3:0] ets, input logic [1:0] edor,
                         input logic edone, input logic eerr, input int ebusy);
        busy_q.push_back(ebusy);
        send_sync(gaps);
        for (int i = 5; i >= 0; i--) send_v(body[i], gaps);
        send(par, 1'b1);
        // Parity is sampled at the coming edge, outputs seen at the next negedge.
        exp_q.push_back('{ets, edor, edone, eerr, cyc + 1});
        if (gaps) send(~par, 1'b0);
        send(1'b0, 1'b0);
        repeat (3) @(negedge IOCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] junk;
        RST       = 1'b1;
        CFG_DIN   = 1'b0;
        CFG_VALID = 1'b0;
        repeat (2) @(negedge IOCLK);
        RST = 1'b0;
        @(negedge IOCLK);
        check("rst_tsmux", 32'(TSMUX_ALL), 32'h0);
        check("rst_dorreg", 32'(DORREG_ALL), 32'h0);
        check("rst_done", 32'(CFG_DONE), 32'h0);
        check("rst_err", 32'(CFG_ERR), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);

        // Bad parity: error pulse only, outputs stay at reset values.
        frame(6'b011100, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1, 7);
        // Good frame.
        frame(6'b011100, 1'b1, 1'b0, 4'b1001, 2'b01, 1'b1, 1'b0, 7);
        // Reconfiguration.
        frame(6'b111001, 1'b0, 1'b0, 4'b0011, 2'b11, 1'b1, 1'b0, 7);

        // Abort after the 4th body bit.
        busy_q.push_back(4);
        send_sync(1'b0);
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        @(posedge IOCLK);
        #2;
        CFG_VALID = 1'b0;
        RST       = 1'b1;
        exp_q.push_back('{4'b0000, 2'b00, 1'b0, 1'b0, -1});
        #1;
        check("async_rst_tsmux", 32'(TSMUX_ALL), 32'h0);
        check("async_rst_dorreg", 32'(DORREG_ALL), 32'h0);
        check("async_rst_done", 32'(CFG_DONE), 32'h0);
        check("async_rst_busy", 32'(BUSY), 32'h0);
        #1;
        RST = 1'b0;
        repeat (3) @(negedge IOCLK);

        // Junk then a good frame, CFG_VALID toggling every other cycle.
        junk = 7'b0011000;
        for (int i = 6; i >= 0; i--) send_v(junk[i], 1'b1);
        frame(6'b011100, 1'b1, 1'b1, 4'b1001, 2'b01, 1'b1, 1'b0, 14);

        repeat (5) @(negedge IOCLK);
        check("events_pending", 32'(exp_q.size()), 32'h0);
        check("busy_pending", 32'(busy_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
